not_pipe_tmr: RTL

- Parametrised successor to the single flip-flop/NOT TMR test design.
- A WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready flow control and a per-stage selectable bitwise inversion.
- Tagged (* tamara_triplicate *) as a mid-size TMR regression target.
- Carries a (* tamara_error_sink *) output for the voter mismatch signal inserted by the triplication pass.

---
 rtl/not_pipe_pkg.sv | 12 +
 rtl/not_pipe_stage.sv | 35 +++
 rtl/not_pipe_tmr.sv | 93 +++++++++
 3 files changed

// File: rtl/not_pipe_pkg.sv
// not_pipe_pkg: shared definitions for the not_pipe_tmr elastic pipeline.
//   INV_MASK_DEFAULT : default inversion pattern (first stage inverts).
//   params_ok()      : returns 1 only for a legal WIDTH/DEPTH/CNT_W set.
package not_pipe_pkg;

  localparam int INV_MASK_DEFAULT = 1;

  function automatic bit params_ok(input int width, input int depth, input int cnt_w);
    return (width >= 1) && (depth >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/not_pipe_stage.sv
// not_pipe_stage: one register stage of the elastic pipeline.
//   clk, rst  : clock, asynchronous active-high reset
//   in_data   : upstream data (stage i-1 output, or pipeline input)
//   in_valid  : upstream valid
//   adv       : this stage may load this cycle (empty or downstream moving)
//   d, v      : registered data and valid
// When INV is set the stage stores the bitwise NOT of its input.
module not_pipe_stage #(
  parameter int WIDTH = 1,
  parameter bit INV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             adv,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
      v <= 1'b0;
    end else if (adv) begin
      v <= in_valid;
      // A bubble only clears valid; data keeps its last value so o stays
      // deterministic while o_valid is low.
      if (in_valid) begin
        d <= INV ? ~in_data : in_data;
      end
    end
  end

endmodule

// File: rtl/not_pipe_tmr.sv
// not_pipe_tmr: WIDTH-bit, DEPTH-stage elastic register pipeline with a
// per-stage selectable inversion, used as a triplication regression target.
//   clk, rst    : clock, asynchronous active-high reset
//   a, a_valid  : input data and valid
//   a_ready     : pipeline accepts input this cycle
//   o, o_valid  : last stage data and valid
//   o_ready     : downstream accepts o this cycle
//   xfer_count  : completed output transfers, wrapping modulo 2^CNT_W
//   err         : voter mismatch sink, tied low until the triplication pass
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and a source holding valid
// keeps its data stable until the transfer. a_ready is combinational from
// o_ready through the advance chain (no skid buffer).
(* tamara_triplicate *)
module not_pipe_tmr
  import not_pipe_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 1,
  parameter logic [DEPTH-1:0] INV_MASK = DEPTH'(INV_MASK_DEFAULT),
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [CNT_W-1:0] xfer_count,
  (* tamara_error_sink *)
  output logic             err
);

  if (!params_ok(WIDTH, DEPTH, CNT_W)) begin : g_param_err
    $error("not_pipe_tmr: WIDTH, DEPTH and CNT_W must all be >= 1");
  end

  logic [WIDTH-1:0] d   [DEPTH];
  logic             v   [DEPTH];
  logic             adv [DEPTH];
  logic [CNT_W-1:0] cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src_d;
    logic             src_v;

    if (i == 0) begin : g_first
      assign src_d = a;
      assign src_v = a_valid;
    end else begin : g_rest
      assign src_d = d[i-1];
      assign src_v = v[i-1];
    end

    // A stage advances when it is empty or everything downstream advances.
    if (i == DEPTH - 1) begin : g_last_adv
      assign adv[i] = !v[i] || o_ready;
    end else begin : g_mid_adv
      assign adv[i] = !v[i] || adv[i+1];
    end

    not_pipe_stage #(
      .WIDTH (WIDTH),
      .INV   (INV_MASK[i])
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_data  (src_d),
      .in_valid (src_v),
      .adv      (adv[i]),
      .d        (d[i]),
      .v        (v[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (o_valid && o_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign a_ready    = adv[0];
  assign o          = d[DEPTH-1];
  assign o_valid    = v[DEPTH-1];
  assign xfer_count = cnt;
  assign err        = 1'b0;

endmodule
